// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer with lap freeze and an internally scanned
// seven-segment digit-mux interface. Single clock, clock-enable based timing.
module stopwatch_timer #(
  parameter int NDIGITS  = 4,
  parameter int CLK_DIV  = 1000000,
  parameter int SCAN_DIV = 100000,
  parameter int DP_POS   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic                   lap,
  input  logic                   mode,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   preset,
  output logic [4*NDIGITS-1:0]   count,
  output logic [3:0]             disp_data,
  output logic [NDIGITS-1:0]     disp_sel,
  output logic                   disp_dp,
  output logic                   running,
  output logic                   lap_active,
  output logic                   done,
  output logic                   wrap
);

  localparam int DW = 4 * NDIGITS;
  localparam int PW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  typedef enum logic {ST_IDLE, ST_RUN} run_state_e;

  run_state_e      state_q, state_d;
  logic [DW-1:0]   count_q, count_d;
  logic [DW-1:0]   lap_val_q, lap_val_d;
  logic            lap_active_q, lap_active_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            done_q, done_d;
  logic            wrap_q, wrap_d;
  logic            start_q, stop_q, clear_q, lap_q, load_q;
  logic            start_d, stop_d, clear_d, lap_d, load_d;
  logic            start_rise, stop_rise, clear_rise, lap_rise, load_rise;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]   scan_idx_q, scan_idx_d;
  logic [NDIGITS-1:0] disp_sel_q, disp_sel_d;
  logic [3:0]      disp_data_q, disp_data_d;
  logic            disp_dp_q, disp_dp_d;
  logic [DW-1:0]   disp_src;

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Run-state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Command edges, tick handling, count/lap next state; commands override the tick
  always_comb begin
    start_d = start;
    stop_d  = stop;
    clear_d = clear;
    lap_d   = lap;
    load_d  = load;
    start_rise = start & ~start_q;
    stop_rise  = stop  & ~stop_q;
    clear_rise = clear & ~clear_q;
    lap_rise   = lap   & ~lap_q;
    load_rise  = load  & ~load_q;

    state_d      = state_q;
    count_d      = count_q;
    presc_d      = presc_q;
    lap_val_d    = lap_val_q;
    lap_active_d = lap_active_q;
    done_d       = 1'b0;
    wrap_d       = 1'b0;

    if (state_q == ST_RUN) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (!mode) begin
          count_d = bcd_inc(count_q);
          wrap_d  = (count_d == '0);
        end else begin
          count_d = bcd_dec(count_q);
          if (count_d == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    if (lap_rise) begin
      if (!lap_active_q) begin
        lap_val_d    = count_q;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end

    // The stop edge only drops the run state; the prescaler still takes its
    // step on that edge and is held from then on.
    if (clear_rise) begin
      count_d      = '0;
      presc_d      = '0;
      state_d      = ST_IDLE;
      lap_active_d = 1'b0;
      done_d       = 1'b0;
      wrap_d       = 1'b0;
    end else if (load_rise) begin
      count_d = bcd_clamp(preset);
      presc_d = '0;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end else if (stop_rise) begin
      state_d = ST_IDLE;
    end else if (start_rise && !(mode && (count_q == '0))) begin
      state_d = ST_RUN;
    end
  end

  // Free-running digit scan and registered display outputs
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    scan_idx_d = scan_idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
    end
    disp_src    = lap_active_q ? lap_val_q : count_q;
    disp_sel_d  = '0;
    disp_data_d = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (scan_idx_q == IW'(i)) begin
        disp_sel_d[i] = 1'b1;
        disp_data_d   = disp_src[4*i +: 4];
      end
    end
    disp_dp_d = (int'(scan_idx_q) == DP_POS);
  end

  // Datapath and display registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q      <= '0;
      lap_val_q    <= '0;
      lap_active_q <= 1'b0;
      presc_q      <= '0;
      done_q       <= 1'b0;
      wrap_q       <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      clear_q      <= 1'b0;
      lap_q        <= 1'b0;
      load_q       <= 1'b0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      disp_sel_q   <= {{(NDIGITS-1){1'b0}}, 1'b1};
      disp_data_q  <= '0;
      disp_dp_q    <= (DP_POS == 0);
    end else begin
      count_q      <= count_d;
      lap_val_q    <= lap_val_d;
      lap_active_q <= lap_active_d;
      presc_q      <= presc_d;
      done_q       <= done_d;
      wrap_q       <= wrap_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      clear_q      <= clear_d;
      lap_q        <= lap_d;
      load_q       <= load_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      disp_sel_q   <= disp_sel_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  assign count      = count_q;
  assign running    = (state_q == ST_RUN);
  assign lap_active = lap_active_q;
  assign done       = done_q;
  assign wrap       = wrap_q;
  assign disp_sel   = disp_sel_q;
  assign disp_data  = disp_data_q;
  assign disp_dp    = disp_dp_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer: expectations are queued with the
// cycle they fall due and checked on the falling edge of that cycle.
module tb_stopwatch_timer;

  localparam int ND = 4;
  localparam int SIG_COUNT   = 0;
  localparam int SIG_RUNNING = 1;
  localparam int SIG_DONE    = 2;
  localparam int SIG_WRAP    = 3;
  localparam int SIG_SEL     = 4;
  localparam int SIG_DATA    = 5;
  localparam int SIG_DP      = 6;
  localparam int SIG_LAPACT  = 7;
  localparam int SIG_SHOWN   = 8;

  typedef struct {
    string       tag;
    int          due;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic          mode = 1'b0, load = 1'b0;
  logic [4*ND-1:0] preset = '0;
  logic [4*ND-1:0] count;
  logic [3:0]    disp_data;
  logic [ND-1:0] disp_sel;
  logic          disp_dp, running, lap_active, done, wrap;

  exp_t        sb[$];
  int          cyc = 0;
  int          rst_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  seen [ND];

  stopwatch_timer #(
    .NDIGITS (ND),
    .CLK_DIV (4),
    .SCAN_DIV(2),
    .DP_POS  (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .mode      (mode),
    .load      (load),
    .preset    (preset),
    .count     (count),
    .disp_data (disp_data),
    .disp_sel  (disp_sel),
    .disp_dp   (disp_dp),
    .running   (running),
    .lap_active(lap_active),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int due, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.due = due;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_COUNT:   return {16'h0, count};
      SIG_RUNNING: return {31'h0, running};
      SIG_DONE:    return {31'h0, done};
      SIG_WRAP:    return {31'h0, wrap};
      SIG_SEL:     return {28'h0, disp_sel};
      SIG_DATA:    return {28'h0, disp_data};
      SIG_DP:      return {31'h0, disp_dp};
      SIG_LAPACT:  return {31'h0, lap_active};
      SIG_SHOWN:   return {16'h0, seen[3], seen[2], seen[1], seen[0]};
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Rebuild the displayed number from the scan, then retire due expectations
  always @(negedge CLK) begin
    for (int i = 0; i < ND; i++) begin
      if (disp_sel[i]) seen[i] = disp_data;
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_val(sb[i].tag, observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    int          e0;
    int          rs;
    int          ld;
    int          c;
    int          idx;
    logic [31:0] scan_val;

    for (int i = 0; i < ND; i++) seen[i] = 4'h0;

    // Power-on reset
    step(3);
    RST = 1'b0;
    rst_cyc = cyc;
    push_exp("rst_count",  cyc, SIG_COUNT,   32'h0);
    push_exp("rst_run",    cyc, SIG_RUNNING, 32'h0);
    push_exp("rst_sel",    cyc, SIG_SEL,     32'h1);
    push_exp("rst_data",   cyc, SIG_DATA,    32'h0);
    push_exp("rst_dp",     cyc, SIG_DP,      32'h0);
    push_exp("rst_done",   cyc, SIG_DONE,    32'h0);
    push_exp("rst_wrap",   cyc, SIG_WRAP,    32'h0);
    push_exp("rst_lapact", cyc, SIG_LAPACT,  32'h0);

    // Reset while counting
    preset = 16'h0123;
    load = 1'b1; step(1); load = 1'b0;
    push_exp("mid_load", cyc, SIG_COUNT, 32'h0123);
    start = 1'b1; step(1); start = 1'b0;
    push_exp("mid_run",   cyc + 1, SIG_RUNNING, 32'h1);
    push_exp("mid_count", cyc + 1, SIG_COUNT,   32'h0123);
    step(1);
    RST = 1'b1; step(1); RST = 1'b0;
    rst_cyc = cyc;
    push_exp("mid_rst_count", cyc, SIG_COUNT,   32'h0);
    push_exp("mid_rst_run",   cyc, SIG_RUNNING, 32'h0);
    push_exp("mid_rst_sel",   cyc, SIG_SEL,     32'h1);
    push_exp("mid_rst_done",  cyc, SIG_DONE,    32'h0);
    push_exp("mid_rst_wrap",  cyc, SIG_WRAP,    32'h0);

    // Up-count carry
    mode = 1'b0;
    preset = 16'h0098;
    load = 1'b1; step(1); load = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    e0 = cyc;
    push_exp("up_hold",   e0 + 3, SIG_COUNT,   32'h0098);
    push_exp("up_99",     e0 + 4, SIG_COUNT,   32'h0099);
    push_exp("up_carry",  e0 + 8, SIG_COUNT,   32'h0100);
    push_exp("up_run",    e0 + 1, SIG_RUNNING, 32'h1);
    step(8);
    stop = 1'b1; step(1); stop = 1'b0;

    // Up-count overflow
    preset = 16'h9999;
    load = 1'b1; step(1); load = 1'b0;
    push_exp("wrap_load", cyc, SIG_COUNT, 32'h9999);
    start = 1'b1; step(1); start = 1'b0;
    e0 = cyc;
    push_exp("wrap_pre",   e0 + 3, SIG_WRAP,    32'h0);
    push_exp("wrap_count", e0 + 4, SIG_COUNT,   32'h0000);
    push_exp("wrap_pulse", e0 + 4, SIG_WRAP,    32'h1);
    push_exp("wrap_post",  e0 + 5, SIG_WRAP,    32'h0);
    push_exp("wrap_run",   e0 + 5, SIG_RUNNING, 32'h1);
    push_exp("wrap_next",  e0 + 8, SIG_COUNT,   32'h0001);
    step(8);
    stop = 1'b1; step(1); stop = 1'b0;

    // Countdown to terminal
    mode = 1'b1;
    preset = 16'h0002;
    load = 1'b1; step(1); load = 1'b0;
    push_exp("dn_load", cyc, SIG_COUNT, 32'h0002);
    start = 1'b1; step(1); start = 1'b0;
    e0 = cyc;
    push_exp("dn_1",        e0 + 4, SIG_COUNT,   32'h0001);
    push_exp("dn_0",        e0 + 8, SIG_COUNT,   32'h0000);
    push_exp("dn_done_pre", e0 + 7, SIG_DONE,    32'h0);
    push_exp("dn_done",     e0 + 8, SIG_DONE,    32'h1);
    push_exp("dn_done_end", e0 + 9, SIG_DONE,    32'h0);
    push_exp("dn_run_pre",  e0 + 7, SIG_RUNNING, 32'h1);
    push_exp("dn_run_end",  e0 + 8, SIG_RUNNING, 32'h0);
    step(11);
    start = 1'b1; step(1); start = 1'b0;
    e0 = cyc;
    push_exp("dn_restart_run",  e0,     SIG_RUNNING, 32'h0);
    push_exp("dn_restart_run1", e0 + 1, SIG_RUNNING, 32'h0);
    for (int k = 0; k < 6; k++) push_exp("dn_restart_done", e0 + k, SIG_DONE, 32'h0);
    step(6);
    mode = 1'b0;

    // Stop / resume keeps the prescaler phase
    clear = 1'b1; step(1); clear = 1'b0;
    push_exp("sr_clear_count", cyc, SIG_COUNT,   32'h0);
    push_exp("sr_clear_run",   cyc, SIG_RUNNING, 32'h0);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    stop = 1'b1; step(1); stop = 1'b0;
    push_exp("sr_stopped", cyc, SIG_RUNNING, 32'h0);
    step(9);
    start = 1'b1; step(1); start = 1'b0;
    rs = cyc;
    push_exp("sr_resume_run", rs,     SIG_RUNNING, 32'h1);
    push_exp("sr_resume_0",   rs + 1, SIG_COUNT,   32'h0000);
    push_exp("sr_resume_1",   rs + 2, SIG_COUNT,   32'h0001);
    step(2);
    stop = 1'b1; step(1); stop = 1'b0;
    step(1);

    // Same-edge priorities
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    push_exp("prio_start_stop", cyc, SIG_RUNNING, 32'h0);
    step(1);
    preset = 16'h0456;
    clear = 1'b1; load = 1'b1; step(1); clear = 1'b0; load = 1'b0;
    push_exp("prio_clear_load", cyc, SIG_COUNT, 32'h0000);
    step(1);

    // Lap freeze
    start = 1'b1; step(1); start = 1'b0;
    e0 = cyc;
    push_exp("lap_count5", e0 + 20, SIG_COUNT,  32'h0005);
    push_exp("lap_off",    e0 + 20, SIG_LAPACT, 32'h0);
    step(20);
    lap = 1'b1; step(1); lap = 1'b0;
    push_exp("lap_on",       e0 + 21, SIG_LAPACT, 32'h1);
    push_exp("lap_shown_a",  e0 + 32, SIG_SHOWN,  32'h0005);
    push_exp("lap_count10",  e0 + 40, SIG_COUNT,  32'h0010);
    push_exp("lap_shown_b",  e0 + 40, SIG_SHOWN,  32'h0005);
    step(19);
    stop = 1'b1; step(1); stop = 1'b0;
    step(1);
    lap = 1'b1; step(1); lap = 1'b0;
    push_exp("lap_release", cyc,      SIG_LAPACT,  32'h0);
    push_exp("lap_stopped", cyc,      SIG_RUNNING, 32'h0);
    push_exp("lap_live",    cyc + 12, SIG_SHOWN,   32'h0010);
    step(13);

    // Preset clamp, scan order and decimal point
    preset = 16'hF3A1;
    load = 1'b1; step(1); load = 1'b0;
    ld = cyc;
    scan_val = 32'h9391;
    push_exp("clamp_count", ld, SIG_COUNT, 32'h9391);
    for (int k = 2; k < 10; k++) begin
      c   = ld + k;
      idx = ((c - rst_cyc - 1) / 2) % 4;
      push_exp("scan_sel",  c, SIG_SEL,  32'h1 << idx);
      push_exp("scan_data", c, SIG_DATA, (scan_val >> (4 * idx)) & 32'hF);
      push_exp("scan_dp",   c, SIG_DP,   (idx == 2) ? 32'h1 : 32'h0);
    end
    step(12);

    check_val("sb_drain", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
